mult_arbiter: RTL and testbench
===============================

// Module: mult_arbiter
// PURPOSE
//  Shares one 16x16 signed parity-checked multiplier (req/ack/result_rdy protocol)
//  among N_CLIENTS requesters using round-robin arbitration. The block sits between
//  the client side and the multiplier. It latches the winning client's operands and
//  sequences the multiplier handshake. It returns the result, result parity and
//  parity-error flag to that client, and aborts any transaction that stalls.
// PARAMETERS
//  N_CLIENTS   4    number of requesters, 2..8
//  TIMEOUT     255  max cycles spent in ISSUE or in WAIT_RDY before abort; 0 = disabled
// PORTS
//  clk                 in   1          clock, all logic on posedge
//  rst                 in   1          asynchronous reset, active-high
//  cli_req             in   N          client i requests; held high until cli_done[i]
//  cli_arg_a           in   N*16       client i operand A at [16*i +: 16], signed
//  cli_arg_a_parity    in   N          client i parity bit for A
//  cli_arg_b           in   N*16       client i operand B at [16*i +: 16], signed
//  cli_arg_b_parity    in   N          client i parity bit for B
//  cli_ack             out  N          one-cycle pulse: operands of client i captured
//  cli_done            out  N          one-cycle pulse: result for client i valid
//  cli_result          out  32         signed product; valid during cli_done, held after
//  cli_result_parity   out  1          parity from multiplier, same timing as cli_result
//  cli_parity_error    out  1          arg_parity_error from multiplier, same timing
//  cli_timeout         out  1          high with cli_done when transaction aborted
//  m_req               out  1          request to multiplier
//  m_arg_a, m_arg_b    out  16 each    latched operands, stable from grant through DONE
//  m_arg_a_parity      out  1          latched parity bit for A
//  m_arg_b_parity      out  1          latched parity bit for B
//  m_ack               in   1          multiplier accepted operands
//  m_result            in   32         multiplier product
//  m_result_parity     in   1          multiplier result parity
//  m_arg_parity_error  in   1          multiplier detected operand parity error
//  m_result_rdy        in   1          multiplier result valid
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr_ptr = N_CLIENTS-1, so client 0 wins first.
//   Reset is asynchronous; m_req drops immediately, even mid-transaction.
//  FSM states: IDLE -> ISSUE -> WAIT_RDY -> DONE -> IDLE. All outputs are registered.
//  IDLE: if |cli_req, grant g = first requester after rr_ptr (cyclic search).
//   Latch g's operands and parities. Pulse cli_ack[g]. Next state ISSUE, tmo_cnt = 0.
//  ISSUE: m_req = 1. When m_ack is sampled high, m_req = 0 next cycle.
//   If m_ack and m_result_rdy are high in the same cycle, go to DONE.
//   Otherwise, on m_ack, go to WAIT_RDY with tmo_cnt = 0.
//  WAIT_RDY: on m_result_rdy, capture m_result, m_result_parity, m_arg_parity_error
//   and go to DONE.
//  Timeout: tmo_cnt increments each cycle in ISSUE and in WAIT_RDY.
//   When tmo_cnt == TIMEOUT-1 with no advance event: go to DONE with cli_timeout = 1,
//   cli_result = 0 and cli_parity_error = 0; m_req = 0.
//  DONE: cli_done[g] = 1 for exactly one cycle. rr_ptr = g. Next state IDLE.
//   cli_timeout clears on the next grant.
//  Latency, ideal multiplier: cli_req at cycle 0, cli_ack at cycle 1, m_req from cycle 2.
//   cli_done follows m_result_rdy by one cycle.
//  A client dropping cli_req mid-transaction does not abort it; cli_done still pulses.
//  No new grant in the DONE cycle: at least one IDLE cycle lies between transactions.
//  Operand changes on cli_arg_* after cli_ack have no effect on the transaction.
//  Product width is 32 bits; the block does no arithmetic and passes m_result unaltered.
// STRUCTURE
//  mult_pkg: arb_state_t enum {IDLE, ISSUE, WAIT_RDY, DONE}; constant MAX_CLIENTS = 8.
//  Sub-module mult_rr_arbiter: combinational round-robin pick.
//   Inputs: req vector, rr_ptr. Outputs: one-hot grant, grant index, any_req.
//  FSM, operand/result registers and timeout counter stay in mult_arbiter.
// TESTING
//  1 Client 1 only, a=3, b=-5, good parity -> cli_ack[1] at cycle 1, m_req from cycle 2,
//    cli_done[1] with cli_result=-15 (0xFFFFFFF1); other cli_done bits stay 0.
//  2 All 4 clients request continuously from reset -> grant order 0,1,2,3,0,
//    exactly one cli_done per transaction.
//  3 Client 2, a=-32768, b=-32768 -> cli_result=0x40000000, parity matches the model.
//  4 Client 0 with bad arg_a parity -> multiplier flags error;
//    cli_parity_error=1 coincident with cli_done[0].
//  5 Multiplier never raises m_ack, TIMEOUT=16 -> cli_timeout=1 and cli_done[0]
//    16 cycles after ISSUE entry; m_req=0; next request is served normally.
//  6 rst raised during WAIT_RDY -> all outputs 0 in the same cycle, state IDLE.
//    With all clients requesting afterwards, client 0 is granted first.

Source files
------------

// File: rtl/mult_arbiter_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
package mult_arbiter_pkg;

  localparam int unsigned MAX_CLIENTS = 8;
  localparam int unsigned OP_W        = 16;
  localparam int unsigned RES_W       = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRdy,
    StDone
  } arb_state_t;

endpackage

// File: rtl/mult_arbiter_if.sv
// Client-side and multiplier-side signals of the arbiter.
// master: the arbiter itself; slave: the clients plus the multiplier around it.
interface mult_arbiter_if #(
  parameter int unsigned N_CLIENTS = 4
);
  import mult_arbiter_pkg::*;

  logic [N_CLIENTS-1:0]      cli_req;
  logic [N_CLIENTS*OP_W-1:0] cli_arg_a;
  logic [N_CLIENTS-1:0]      cli_arg_a_parity;
  logic [N_CLIENTS*OP_W-1:0] cli_arg_b;
  logic [N_CLIENTS-1:0]      cli_arg_b_parity;
  logic [N_CLIENTS-1:0]      cli_ack;
  logic [N_CLIENTS-1:0]      cli_done;
  logic [RES_W-1:0]          cli_result;
  logic                      cli_result_parity;
  logic                      cli_parity_error;
  logic                      cli_timeout;

  logic                      m_req;
  logic [OP_W-1:0]           m_arg_a;
  logic [OP_W-1:0]           m_arg_b;
  logic                      m_arg_a_parity;
  logic                      m_arg_b_parity;
  logic                      m_ack;
  logic [RES_W-1:0]          m_result;
  logic                      m_result_parity;
  logic                      m_arg_parity_error;
  logic                      m_result_rdy;

  modport master (
    input  cli_req, cli_arg_a, cli_arg_a_parity, cli_arg_b, cli_arg_b_parity,
    output cli_ack, cli_done, cli_result, cli_result_parity, cli_parity_error, cli_timeout,
    output m_req, m_arg_a, m_arg_b, m_arg_a_parity, m_arg_b_parity,
    input  m_ack, m_result, m_result_parity, m_arg_parity_error, m_result_rdy
  );

  modport slave (
    output cli_req, cli_arg_a, cli_arg_a_parity, cli_arg_b, cli_arg_b_parity,
    input  cli_ack, cli_done, cli_result, cli_result_parity, cli_parity_error, cli_timeout,
    input  m_req, m_arg_a, m_arg_b, m_arg_a_parity, m_arg_b_parity,
    output m_ack, m_result, m_result_parity, m_arg_parity_error, m_result_rdy
  );

endinterface

// File: rtl/mult_arbiter_rr.sv
// Combinational round-robin pick: first requester strictly after ptr_i, cyclically.
module mult_arbiter_rr #(
  parameter int unsigned N_CLIENTS = 4,
  parameter int unsigned IdxW      = $clog2(N_CLIENTS)
) (
  input  logic [N_CLIENTS-1:0] req_i,
  input  logic [IdxW-1:0]      ptr_i,
  output logic [N_CLIENTS-1:0] gnt_o,
  output logic [IdxW-1:0]      idx_o,
  output logic                 any_o
);

  logic [IdxW-1:0] cand;
  logic            found;

  // Scan N_CLIENTS positions starting one past the last winner.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 1; off <= N_CLIENTS; off++) begin
      cand = IdxW'((32'(ptr_i) + off) % N_CLIENTS);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one parity-checked multiplier among N_CLIENTS requesters,
// with operand latching, handshake sequencing and stall timeout.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int unsigned N_CLIENTS = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input logic           clk,
  input logic           rst,
  mult_arbiter_if.master bus
);

  localparam int unsigned IdxW = $clog2(N_CLIENTS);
  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  if (N_CLIENTS < 2 || N_CLIENTS > MAX_CLIENTS) begin : g_bad_clients
    $error("mult_arbiter: N_CLIENTS out of range");
  end

  arb_state_t           state_q, state_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]      gnt_idx_q, gnt_idx_d;
  logic [TmoW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [OP_W-1:0]      arg_a_q, arg_a_d, arg_b_q, arg_b_d;
  logic                 arg_a_par_q, arg_a_par_d, arg_b_par_q, arg_b_par_d;
  logic                 m_req_q, m_req_d;
  logic [N_CLIENTS-1:0] cli_ack_q, cli_ack_d, cli_done_q, cli_done_d;
  logic [RES_W-1:0]     result_q, result_d;
  logic                 res_par_q, res_par_d, par_err_q, par_err_d, timeout_q, timeout_d;

  logic [N_CLIENTS-1:0] rr_gnt;
  logic [IdxW-1:0]      rr_idx;
  logic                 rr_any;
  logic                 tmo_hit, m_acked, fin_ok, fin_abort;
  logic [N_CLIENTS-1:0] done_vec;

  mult_arbiter_rr #(
    .N_CLIENTS(N_CLIENTS),
    .IdxW     (IdxW)
  ) u_rr (
    .req_i(bus.cli_req),
    .ptr_i(rr_ptr_q),
    .gnt_o(rr_gnt),
    .idx_o(rr_idx),
    .any_o(rr_any)
  );

  assign tmo_hit  = (TIMEOUT != 0) && (tmo_cnt_q == TmoW'(TIMEOUT - 1));
  // Only an ack to a request we are actually presenting counts.
  assign m_acked  = bus.m_ack && m_req_q;
  assign done_vec = {{(N_CLIENTS-1){1'b0}}, 1'b1} << gnt_idx_q;

  // Next-state, operand/result capture and one-cycle pulse generation.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_idx_d   = gnt_idx_q;
    tmo_cnt_d   = tmo_cnt_q;
    arg_a_d     = arg_a_q;
    arg_b_d     = arg_b_q;
    arg_a_par_d = arg_a_par_q;
    arg_b_par_d = arg_b_par_q;
    m_req_d     = 1'b0;
    cli_ack_d   = '0;
    cli_done_d  = '0;
    result_d    = result_q;
    res_par_d   = res_par_q;
    par_err_d   = par_err_q;
    timeout_d   = timeout_q;
    fin_ok      = 1'b0;
    fin_abort   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rr_any) begin
          gnt_idx_d   = rr_idx;
          arg_a_d     = bus.cli_arg_a[OP_W*rr_idx +: OP_W];
          arg_b_d     = bus.cli_arg_b[OP_W*rr_idx +: OP_W];
          arg_a_par_d = bus.cli_arg_a_parity[rr_idx];
          arg_b_par_d = bus.cli_arg_b_parity[rr_idx];
          cli_ack_d   = rr_gnt;
          timeout_d   = 1'b0;
          tmo_cnt_d   = '0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        if (m_acked) begin
          tmo_cnt_d = '0;
          if (bus.m_result_rdy) fin_ok = 1'b1;
          else                  state_d = StWaitRdy;
        end else if (tmo_hit) begin
          fin_abort = 1'b1;
        end else begin
          m_req_d = 1'b1;
        end
      end
      StWaitRdy: begin
        tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        if (bus.m_result_rdy) fin_ok = 1'b1;
        else if (tmo_hit)     fin_abort = 1'b1;
      end
      StDone: begin
        rr_ptr_d = gnt_idx_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (fin_ok) begin
      result_d   = bus.m_result;
      res_par_d  = bus.m_result_parity;
      par_err_d  = bus.m_arg_parity_error;
      cli_done_d = done_vec;
      state_d    = StDone;
    end
    if (fin_abort) begin
      result_d   = '0;
      res_par_d  = 1'b0;
      par_err_d  = 1'b0;
      timeout_d  = 1'b1;
      cli_done_d = done_vec;
      state_d    = StDone;
    end
  end

  // State and output registers; reset drops m_req immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= IdxW'(N_CLIENTS - 1);
      gnt_idx_q   <= '0;
      tmo_cnt_q   <= '0;
      arg_a_q     <= '0;
      arg_b_q     <= '0;
      arg_a_par_q <= 1'b0;
      arg_b_par_q <= 1'b0;
      m_req_q     <= 1'b0;
      cli_ack_q   <= '0;
      cli_done_q  <= '0;
      result_q    <= '0;
      res_par_q   <= 1'b0;
      par_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      tmo_cnt_q   <= tmo_cnt_d;
      arg_a_q     <= arg_a_d;
      arg_b_q     <= arg_b_d;
      arg_a_par_q <= arg_a_par_d;
      arg_b_par_q <= arg_b_par_d;
      m_req_q     <= m_req_d;
      cli_ack_q   <= cli_ack_d;
      cli_done_q  <= cli_done_d;
      result_q    <= result_d;
      res_par_q   <= res_par_d;
      par_err_q   <= par_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.cli_ack           = cli_ack_q;
  assign bus.cli_done          = cli_done_q;
  assign bus.cli_result        = result_q;
  assign bus.cli_result_parity = res_par_q;
  assign bus.cli_parity_error  = par_err_q;
  assign bus.cli_timeout       = timeout_q;
  assign bus.m_req             = m_req_q;
  assign bus.m_arg_a           = arg_a_q;
  assign bus.m_arg_b           = arg_b_q;
  assign bus.m_arg_a_parity    = arg_a_par_q;
  assign bus.m_arg_b_parity    = arg_b_par_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed scenarios plus a randomized
// round-robin run checked against a behavioural model.
module tb_mult_arbiter;
  import mult_arbiter_pkg::*;

  localparam int unsigned NC  = 4;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  mult_arbiter_if #(.N_CLIENTS(NC)) bus ();

  mult_arbiter #(
    .N_CLIENTS(NC),
    .TIMEOUT  (TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Client-side stimulus state.
  logic [15:0]   ca [NC];
  logic [15:0]   cb [NC];
  bit            bad_a [NC];
  bit            bad_b [NC];
  logic [NC-1:0] req;

  // Multiplier model controls and state.
  bit          mul_ack_en = 1'b1;
  int          mul_lat = 0;
  bit          mbusy = 1'b0;
  int          mcnt = 0;
  int          rdy_cyc = -1;
  logic [31:0] mprod;
  bit          mperr;

  function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sb;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    return 32'(sa * sb);
  endfunction

  function automatic int rr_pick(input logic [NC-1:0] m, input int last);
    for (int k = 1; k <= int'(NC); k++) begin
      int c;
      c = (last + k) % int'(NC);
      if (((m >> c) & NC'(1)) != 0) return c;
    end
    return -1;
  endfunction

  function automatic logic [77:0] all_outs();
    return {bus.cli_ack, bus.cli_done, bus.cli_result, bus.cli_result_parity,
            bus.cli_parity_error, bus.cli_timeout, bus.m_req, bus.m_arg_a, bus.m_arg_b,
            bus.m_arg_a_parity, bus.m_arg_b_parity};
  endfunction

  // Behavioural multiplier: acks a presented request, answers after mul_lat cycles,
  // and drives noise on the result lines whenever it is not presenting a result.
  always @(negedge clk) begin
    if (rst) begin
      bus.m_ack = 1'b0;
      bus.m_result_rdy = 1'b0;
      bus.m_result = '0;
      bus.m_result_parity = 1'b0;
      bus.m_arg_parity_error = 1'b0;
      mbusy = 1'b0;
      mcnt = 0;
    end else begin
      bus.m_ack = 1'b0;
      bus.m_result_rdy = 1'b0;
      bus.m_result = $urandom;
      bus.m_result_parity = 1'($urandom);
      bus.m_arg_parity_error = 1'($urandom);
      if (mbusy) begin
        mcnt--;
        if (mcnt == 0) begin
          bus.m_result_rdy = 1'b1;
          bus.m_result = mprod;
          bus.m_result_parity = ^mprod;
          bus.m_arg_parity_error = mperr;
          rdy_cyc = cyc;
          mbusy = 1'b0;
        end
      end else if (bus.m_req === 1'b1 && mul_ack_en) begin
        bus.m_ack = 1'b1;
        mprod = prod(bus.m_arg_a, bus.m_arg_b);
        mperr = ((^bus.m_arg_a) != bus.m_arg_a_parity) || ((^bus.m_arg_b) != bus.m_arg_b_parity);
        if (mul_lat == 0) begin
          bus.m_result_rdy = 1'b1;
          bus.m_result = mprod;
          bus.m_result_parity = ^mprod;
          bus.m_arg_parity_error = mperr;
          rdy_cyc = cyc;
        end else begin
          mbusy = 1'b1;
          mcnt = mul_lat;
        end
      end
    end
  end

  task automatic drive_clients();
    for (int i = 0; i < int'(NC); i++) begin
      bus.cli_arg_a[16*i +: 16] = ca[i];
      bus.cli_arg_b[16*i +: 16] = cb[i];
      bus.cli_arg_a_parity[i] = (^ca[i]) ^ bad_a[i];
      bus.cli_arg_b_parity[i] = (^cb[i]) ^ bad_b[i];
    end
    bus.cli_req = req;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(output bit ok, output logic [NC-1:0] v, output int c);
    ok = 1'b0; v = '0; c = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.cli_ack !== '0) begin
        ok = 1'b1; v = bus.cli_ack; c = cyc;
        return;
      end
    end
  endtask

  task automatic wait_done(output bit ok, output logic [NC-1:0] v, output int c,
                           output logic [31:0] r, output bit rp, output bit pe, output bit to);
    ok = 1'b0; v = '0; c = -1; r = '0; rp = 1'b0; pe = 1'b0; to = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.cli_done !== '0) begin
        ok = 1'b1; v = bus.cli_done; c = cyc; r = bus.cli_result;
        rp = bus.cli_result_parity; pe = bus.cli_parity_error; to = bus.cli_timeout;
        return;
      end
    end
  endtask

  task automatic test_reset();
    req = '1;
    for (int i = 0; i < int'(NC); i++) begin
      ca[i] = 16'h1111 * 16'(i + 1); cb[i] = 16'h0101; bad_a[i] = 1'b0; bad_b[i] = 1'b0;
    end
    drive_clients();
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    req = '0;
    drive_clients();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL idle_after_reset: got %h expected 0", all_outs());
    end
  endtask

  task automatic test_single();
    bit ok, rp, pe, to;
    logic [NC-1:0] v;
    logic [31:0] r;
    int c0, dc;
    do_reset();
    mul_ack_en = 1'b1; mul_lat = 0;
    ca[1] = 16'd3; cb[1] = 16'hFFFB; bad_a[1] = 1'b0; bad_b[1] = 1'b0;
    req = 4'b0010;
    drive_clients();
    c0 = cyc;
    @(negedge clk);
    checks++;
    if (bus.cli_ack !== 4'b0010 || bus.m_req !== 1'b0) begin
      errors++; $display("FAIL single_ack_cycle1: ack=%b m_req=%b expected ack=0010 m_req=0",
                         bus.cli_ack, bus.m_req);
    end
    @(negedge clk);
    checks++;
    if (bus.m_req !== 1'b1 || bus.cli_ack !== 4'b0000) begin
      errors++; $display("FAIL single_mreq_cycle2: m_req=%b ack=%b expected 1 and 0000",
                         bus.m_req, bus.cli_ack);
    end
    wait_done(ok, v, dc, r, rp, pe, to);
    req = '0;
    drive_clients();
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done_timeout: no cli_done within bound"); end
    checks++;
    if (v !== 4'b0010) begin
      errors++; $display("FAIL single_done_vec: got %b expected 0010", v);
    end
    checks++;
    if (r !== 32'hFFFFFFF1 || rp !== 1'b1 || pe !== 1'b0 || to !== 1'b0) begin
      errors++; $display("FAIL single_result: got %h rp=%b pe=%b to=%b expected fffffff1 1 0 0",
                         r, rp, pe, to);
    end
    checks++;
    if (dc !== c0 + 3 || dc !== rdy_cyc + 1) begin
      errors++; $display("FAIL single_latency: done at %0d expected %0d (rdy at %0d)",
                         dc - c0, 3, rdy_cyc - c0);
    end
  endtask

  task automatic test_all_clients();
    bit ok, rp, pe, to;
    logic [NC-1:0] v;
    logic [31:0] r;
    int dc, exp_c;
    int order [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < int'(NC); i++) begin
      ca[i] = 16'($urandom); cb[i] = 16'($urandom); bad_a[i] = 1'b0; bad_b[i] = 1'b0;
    end
    req = '1;
    drive_clients();
    mul_lat = 1;
    do_reset();
    for (int t = 0; t < 5; t++) begin
      exp_c = order[t];
      wait_done(ok, v, dc, r, rp, pe, to);
      if (t == 4) begin req = '0; drive_clients(); end
      checks++;
      if (!ok || v !== (NC'(1) << exp_c) || $countones(v) != 1) begin
        errors++; $display("FAIL all_order[%0d]: got %b expected %b", t, v, NC'(1) << exp_c);
      end
      checks++;
      if (r !== prod(ca[exp_c], cb[exp_c]) || rp !== ^prod(ca[exp_c], cb[exp_c])) begin
        errors++; $display("FAIL all_result[%0d]: got %h/%b expected %h", t, r, rp,
                           prod(ca[exp_c], cb[exp_c]));
      end
    end
  endtask

  task automatic test_min_operands();
    bit ok, rp, pe, to;
    logic [NC-1:0] v;
    logic [31:0] r;
    int dc;
    @(negedge clk);
    ca[2] = 16'h8000; cb[2] = 16'h8000; bad_a[2] = 1'b0; bad_b[2] = 1'b0;
    req = 4'b0100; mul_lat = 2;
    drive_clients();
    wait_done(ok, v, dc, r, rp, pe, to);
    req = '0; drive_clients();
    checks++;
    if (!ok || v !== 4'b0100 || r !== 32'h40000000 || rp !== 1'b1 || pe !== 1'b0) begin
      errors++; $display("FAIL min_operands: v=%b r=%h rp=%b pe=%b expected 0100 40000000 1 0",
                         v, r, rp, pe);
    end
  endtask

  task automatic test_parity_error();
    bit ok, rp, pe, to;
    logic [NC-1:0] v;
    logic [31:0] r;
    int dc;
    @(negedge clk);
    ca[0] = 16'($urandom); cb[0] = 16'($urandom); bad_a[0] = 1'b1; bad_b[0] = 1'b0;
    req = 4'b0001; mul_lat = 0;
    drive_clients();
    wait_done(ok, v, dc, r, rp, pe, to);
    req = '0; bad_a[0] = 1'b0; drive_clients();
    checks++;
    if (!ok || v !== 4'b0001 || pe !== 1'b1 || to !== 1'b0) begin
      errors++; $display("FAIL parity_error: v=%b pe=%b to=%b expected 0001 1 0", v, pe, to);
    end
    checks++;
    if (r !== prod(ca[0], cb[0])) begin
      errors++; $display("FAIL parity_error_result: got %h expected %h", r, prod(ca[0], cb[0]));
    end
  endtask

  task automatic test_timeout();
    bit ok, okd, rp, pe, to;
    logic [NC-1:0] v, av;
    logic [31:0] r;
    int ac, dc;
    do_reset();
    mul_ack_en = 1'b0;
    ca[0] = 16'h00FF; cb[0] = 16'h0F0F; bad_a[0] = 1'b0; bad_b[0] = 1'b0;
    req = 4'b0001;
    drive_clients();
    wait_ack(ok, av, ac);
    wait_done(okd, v, dc, r, rp, pe, to);
    req = '0; drive_clients();
    checks++;
    if (!ok || !okd || dc !== ac + int'(TMO)) begin
      errors++; $display("FAIL issue_timeout_cycle: done %0d cycles after issue, expected %0d",
                         dc - ac, TMO);
    end
    checks++;
    if (to !== 1'b1 || v !== 4'b0001 || r !== '0 || pe !== 1'b0 || bus.m_req !== 1'b0) begin
      errors++; $display("FAIL issue_timeout_flags: to=%b v=%b r=%h pe=%b m_req=%b expected 1 0001 0 0 0",
                         to, v, r, pe, bus.m_req);
    end
    // Served normally afterwards; requester drops its request right after the ack.
    mul_ack_en = 1'b1; mul_lat = 2;
    @(negedge clk);
    req = 4'b0001; drive_clients();
    wait_ack(ok, av, ac);
    req = '0; drive_clients();
    wait_done(okd, v, dc, r, rp, pe, to);
    checks++;
    if (!okd || to !== 1'b0 || v !== 4'b0001 || r !== prod(16'h00FF, 16'h0F0F)) begin
      errors++; $display("FAIL after_timeout: to=%b v=%b r=%h expected 0 0001 %h",
                         to, v, r, prod(16'h00FF, 16'h0F0F));
    end
    // Stall in WAIT_RDY: ack arrives, result does not.
    mul_lat = 40;
    ca[1] = 16'h0002; cb[1] = 16'h0003; bad_a[1] = 1'b0; bad_b[1] = 1'b0;
    req = 4'b0010; drive_clients();
    wait_ack(ok, av, ac);
    wait_done(okd, v, dc, r, rp, pe, to);
    req = '0; drive_clients();
    checks++;
    if (!okd || to !== 1'b1 || v !== 4'b0010 || dc !== ac + int'(TMO) + 2) begin
      errors++; $display("FAIL wait_rdy_timeout: to=%b v=%b delay=%0d expected 1 0010 %0d",
                         to, v, dc - ac, TMO + 2);
    end
    repeat (50) @(negedge clk);
  endtask

  task automatic test_random();
    bit ok, okd, rp, pe, to;
    logic [NC-1:0] v, av, newm;
    logic [31:0] r;
    logic [15:0] ea, eb;
    bit epe;
    int ac, dc, last, g;
    mul_ack_en = 1'b1;
    req = '0; drive_clients();
    do_reset();
    last = int'(NC) - 1;
    for (int t = 0; t < 40; t++) begin
      newm = NC'($urandom) & ~req;
      if ((req | newm) == '0) newm = NC'(1) << $urandom_range(0, NC - 1);
      for (int i = 0; i < int'(NC); i++) begin
        if (newm[i]) begin
          ca[i] = 16'($urandom); cb[i] = 16'($urandom);
          bad_a[i] = ($urandom_range(0, 5) == 0);
          bad_b[i] = ($urandom_range(0, 5) == 0);
        end
      end
      req = req | newm;
      mul_lat = $urandom_range(0, 4);
      drive_clients();
      g = rr_pick(req, last);
      ea = ca[g]; eb = cb[g]; epe = bad_a[g] | bad_b[g];
      wait_ack(ok, av, ac);
      checks++;
      if (!ok || av !== (NC'(1) << g)) begin
        errors++; $display("FAIL rand_grant[%0d]: got %b expected %b", t, av, NC'(1) << g);
      end
      // Operands changed after capture must not reach the multiplier.
      ca[g] = ~ca[g]; cb[g] = cb[g] + 16'd7;
      drive_clients();
      wait_done(okd, v, dc, r, rp, pe, to);
      checks++;
      if (!okd || v !== (NC'(1) << g) || r !== prod(ea, eb) || rp !== ^prod(ea, eb) ||
          pe !== epe || to !== 1'b0) begin
        errors++; $display("FAIL rand_done[%0d]: v=%b r=%h rp=%b pe=%b to=%b expected %b %h %b %b 0",
                           t, v, r, rp, pe, to, NC'(1) << g, prod(ea, eb), ^prod(ea, eb), epe);
      end
      last = g;
      req[g] = 1'b0;
      drive_clients();
    end
  endtask

  task automatic test_reset_mid();
    bit ok, okd, rp, pe, to;
    logic [NC-1:0] v, av;
    logic [31:0] r;
    int ac, dc;
    @(negedge clk);
    mul_lat = 30;
    ca[2] = 16'h5A5A; cb[2] = 16'h0123; bad_a[2] = 1'b0; bad_b[2] = 1'b0;
    req = 4'b0100; drive_clients();
    wait_ack(ok, av, ac);
    repeat (4) @(negedge clk);
    checks++;
    if (bus.m_req !== 1'b0 || bus.m_arg_a !== 16'h5A5A) begin
      errors++; $display("FAIL pre_reset_wait: m_req=%b m_arg_a=%h expected 0 5a5a",
                         bus.m_req, bus.m_arg_a);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL async_reset: got %h expected 0", all_outs());
    end
    for (int i = 0; i < int'(NC); i++) begin
      ca[i] = 16'($urandom); cb[i] = 16'($urandom); bad_a[i] = 1'b0; bad_b[i] = 1'b0;
    end
    req = '1; mul_lat = 1; drive_clients();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ack(ok, av, ac);
    checks++;
    if (!ok || av !== 4'b0001) begin
      errors++; $display("FAIL first_after_reset: got %b expected 0001", av);
    end
    wait_done(okd, v, dc, r, rp, pe, to);
    req = '0; drive_clients();
    checks++;
    if (!okd || v !== 4'b0001 || r !== prod(ca[0], cb[0])) begin
      errors++; $display("FAIL after_reset_result: v=%b r=%h expected 0001 %h",
                         v, r, prod(ca[0], cb[0]));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_clients();
    test_min_operands();
    test_parity_error();
    test_timeout();
    test_random();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
